// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared types and sizes for the register-file writeback controller
package rf_ctrl_pkg;
  typedef enum logic {INIT, RUN} wb_state_t;
  localparam int NUM_ARCH_REGS = 32;
  localparam int REG_IDX_W = 5;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; req/ptr in, one-hot gnt, binary gnt_idx, any_gnt out
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any_gnt
);
  always_comb begin
    int i;
    i = 0;
    gnt = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < N; k++) begin
      i = (int'(ptr) + k) % N;
      if (!any_gnt && req[i]) begin
        any_gnt = 1'b1;
        gnt[i] = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: owns the regfile write port; zero-clears x1..x31 after reset, then round-robins writeback requesters
//   in : clk, rst_n, req_valid[N], req_rd[N*5], req_data[N*REG_WIDTH]
//   out: req_ready[N] (one-hot), rf_rd, rf_din, rf_reg_write, init_done
module regfile_wb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int NUM_REQ    = 2,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*REG_IDX_W-1:0]   req_rd,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [REG_IDX_W-1:0]           rf_rd,
  output logic [REG_WIDTH-1:0]           rf_din,
  output logic                           rf_reg_write,
  output logic                           init_done
);
  localparam int PW = $clog2(NUM_REQ);
  wb_state_t state_q, state_d;
  logic [REG_IDX_W-1:0] init_idx_q, init_idx_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0] gnt_idx;
  logic any_gnt, run, hs;
  logic [REG_IDX_W-1:0] sel_rd;
  logic [REG_WIDTH-1:0] sel_data;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );
  // Outputs are gated by rst_n directly so they fall the moment reset asserts,
  // not at the next clock edge.
  always_comb begin
    run = state_q == RUN;
    hs = run && any_gnt;
    sel_rd = req_rd[REG_IDX_W*gnt_idx +: REG_IDX_W];
    sel_data = req_data[REG_WIDTH*gnt_idx +: REG_WIDTH];
    state_d = (!run && init_idx_q == REG_IDX_W'(NUM_ARCH_REGS-1)) ? RUN : state_q;
    init_idx_d = run ? init_idx_q : init_idx_q + 1'b1;
    rr_ptr_d = !hs ? rr_ptr_q : (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    req_ready = (rst_n && run) ? gnt : '0;
    rf_rd = !rst_n ? '0 : run ? (hs ? sel_rd : '0) : init_idx_q;
    rf_din = (rst_n && hs) ? sel_data : '0;
    rf_reg_write = rst_n && (run ? hs && sel_rd != '0 : 1'b1);
    init_done = rst_n && run;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_CLEAR ? INIT : RUN;
      init_idx_q <= REG_IDX_W'(1);
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      init_idx_q <= init_idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: randomized self-checking bench for regfile_wb_ctrl against a behavioural model
module tb_regfile_wb_ctrl;
  localparam int N = 2;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*5-1:0] req_rd;
  logic [N*W-1:0] req_data;
  logic [4:0] rf_rd;
  logic [W-1:0] rf_din;
  logic rf_reg_write, init_done;
  logic [N-1:0] pv;
  logic [4:0] prd [N];
  logic [W-1:0] pdat [N];
  logic [W-1:0] dut_rf [32];
  logic [W-1:0] ref_rf [32];
  logic [N-1:0] last_ready;
  int n_vec = 0, n_err = 0, icnt = 0, mptr = 0, g = -1;
  bit mrun = 1'b0;
  always #5 clk = ~clk;
  regfile_wb_ctrl #(.REG_WIDTH(W), .NUM_REQ(N), .INIT_CLEAR(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rf_rd        (rf_rd),
    .rf_din       (rf_din),
    .rf_reg_write (rf_reg_write),
    .init_done    (init_done)
  );
  always_comb begin
    req_valid = pv;
    req_rd = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_rd[5*i +: 5] = prd[i];
      req_data[W*i +: W] = pdat[i];
    end
  end
  always @(posedge clk) if (rf_reg_write) dut_rf[rf_rd] <= rf_din;
  function automatic logic [W-1:0] rs_read(int a);
    return (a == 0) ? '0 : dut_rf[a];
  endfunction
  logic [N-1:0] wait_q = '0;
  logic [4:0] rd_q [N];
  logic [W-1:0] dat_q [N];
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_n && wait_q[i])
        assert (req_valid[i] && req_rd[5*i +: 5] == rd_q[i] && req_data[W*i +: W] == dat_q[i])
          else $error("requester %0d dropped or changed a pending write", i);
      wait_q[i] <= rst_n && req_valid[i] && !req_ready[i];
      rd_q[i] <= req_rd[5*i +: 5];
      dat_q[i] <= req_data[W*i +: W];
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic [63:0] e_ready, e_rd, e_din, e_we;
    int rs;
    @(negedge clk);
    g = -1;
    if (mrun)
      for (int k = 0; k < N; k++)
        if (g < 0 && pv[(mptr + k) % N]) g = (mptr + k) % N;
    e_ready = (g >= 0) ? (64'd1 << g) : 64'd0;
    e_rd = !mrun ? 64'(icnt + 1) : (g >= 0) ? 64'(prd[g]) : 64'd0;
    e_din = (g >= 0) ? 64'(pdat[g]) : 64'd0;
    e_we = !mrun ? 64'd1 : (g >= 0 && prd[g] != 0) ? 64'd1 : 64'd0;
    last_ready = req_ready;
    check("ready", 64'(req_ready), e_ready);
    check("rf_rd", 64'(rf_rd), e_rd);
    check("rf_din", 64'(rf_din), e_din);
    check("rf_reg_write", 64'(rf_reg_write), e_we);
    check("init_done", 64'(init_done), 64'(mrun));
    if (mrun) begin
      rs = $urandom_range(31);
      check($sformatf("rs1_x%0d", rs), 64'(rs_read(rs)), 64'(ref_rf[rs]));
    end
    @(posedge clk);
    #1;
    if (!mrun) begin
      ref_rf[icnt + 1] = '0;
      icnt++;
      if (icnt == 31) mrun = 1'b1;
    end else if (g >= 0) begin
      mptr = (g + 1) % N;
      if (prd[g] != 0) ref_rf[prd[g]] = pdat[g];
      pv[g] = 1'b0;
    end
  endtask
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rf_rd", 64'(rf_rd), 64'd0);
    check("rst_rf_din", 64'(rf_din), 64'd0);
    check("rst_we", 64'(rf_reg_write), 64'd0);
    check("rst_done", 64'(init_done), 64'd0);
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    icnt = 0;
    mrun = 1'b0;
    mptr = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    pv = '0;
    for (int i = 0; i < N; i++) begin
      prd[i] = '0;
      pdat[i] = '0;
    end
    ref_rf[0] = '0;
    do_reset(3);
    repeat (32) tick();
    pv[0] = 1'b1; prd[0] = 5'd5; pdat[0] = 32'hDEADBEEF;
    tick();
    check("t2_ready", 64'(last_ready), 64'd1);
    check("t2_x5", 64'(rs_read(5)), 64'hDEADBEEF);
    pv[1] = 1'b1; prd[1] = 5'd0; pdat[1] = 32'h1234;
    tick();
    check("t4_ready", 64'(last_ready), 64'd2);
    check("t4_x0", 64'(rs_read(0)), 64'd0);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && c < 3) begin
          pv[i] = 1'b1;
          prd[i] = 5'(i + 1);
          pdat[i] = $urandom;
        end
      tick();
      check($sformatf("t3_gnt%0d", c), 64'(last_ready), (c % 2) ? 64'd2 : 64'd1);
    end
    pv = '1;
    prd[0] = 5'd7; pdat[0] = 32'hA5A5_0001;
    prd[1] = 5'd7; pdat[1] = 32'h5A5A_0002;
    tick();
    check("t5_first", 64'(last_ready), 64'd1);
    tick();
    check("t5_x7", 64'(rs_read(7)), 64'h5A5A_0002);
    repeat (300) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(1) == 1) begin
          pv[i] = 1'b1;
          prd[i] = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
          pdat[i] = $urandom;
        end
      tick();
    end
    repeat (4) tick();
    do_reset(2);
    repeat (11) tick();
    #3;
    check("t6_rd_before_rst", 64'(rf_rd), 64'd12);
    do_reset(2);
    repeat (32) tick();
    pv[1] = 1'b1; prd[1] = 5'd20; pdat[1] = 32'hC0FFEE01;
    #3;
    check("t6_ready_before_rst", 64'(req_ready), 64'd2);
    do_reset(2);
    repeat (31) tick();
    tick();
    check("t6_reack", 64'(last_ready), 64'd2);
    check("t6_x20", 64'(rs_read(20)), 64'hC0FFEE01);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
